// File: rtl/fetch_id_queue_pkg.sv
// Shared types and constants for the IF->ID fetch-group queue.
// A group is four 16-bit slots; slot0 sits in the most significant position.
package fetch_id_queue_pkg;

    localparam int SLOT_W = 16;
    localparam int SLOTS  = 4;
    localparam int GRP_W  = SLOT_W * SLOTS;

    localparam logic [SLOT_W-1:0] NOP_INST = 16'h0000;

    typedef struct packed {
        logic [GRP_W-1:0] inst;
        logic [GRP_W-1:0] pc;
        logic [GRP_W-1:0] recv_pc;
        logic [SLOTS-1:0] pred;
        logic [SLOTS-1:0] slot_vld;
    } fetch_grp_t;

endpackage

// File: rtl/fetch_grp_mem.sv
// Fetch-group storage: one write port, one asynchronous read port, data not reset.
// Write lands on the clock edge; read is combinational from rd_ptr; no flow control here.
module fetch_grp_mem
    import fetch_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  fetch_grp_t       wr_dat,
    input  logic [PTR_W-1:0] rd_ptr,
    output fetch_grp_t       rd_dat
);

    fetch_grp_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_id_queue.sv
// Buffers fetch groups for decode; a push is visible at the head one cycle later, no bypass.
// Backpressure: full_out_to_FE from registered count only; decode stalls via stll_ftch_in_frm_ID.
module fetch_id_queue
    import fetch_id_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [SLOT_W-1:0] NOP_INST = fetch_id_queue_pkg::NOP_INST,
    parameter int                PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grp_vld_in_frm_FE,
    input  logic [63:0]      inst_in_frm_FE,
    input  logic [63:0]      pc_in_frm_FE,
    input  logic [63:0]      recv_pc_in_frm_FE,
    input  logic [3:0]       pred_result_in_frm_FE,
    input  logic [3:0]       slot_vld_in_frm_FE,
    input  logic             stll_ftch_in_frm_ID,
    input  logic             mis_pred_in_frm_ROB,
    output logic             full_out_to_FE,
    output logic             grp_vld_out_to_ID,
    output logic [63:0]      inst_out_to_ID,
    output logic [63:0]      pc_out_to_ID,
    output logic [63:0]      recv_pc_out_to_ID,
    output logic [3:0]       pred_result_out_to_ID,
    output logic [PTR_W:0]   cnt_out
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             empty;
    logic             push;
    logic             pop;
    fetch_grp_t       wr_grp;
    fetch_grp_t       head_grp;

    assign empty             = (cnt == '0);
    assign full_out_to_FE    = (cnt == DEPTH_CNT);
    assign grp_vld_out_to_ID = ~empty;
    assign cnt_out           = cnt;

    // A mispredict squashes both sides of the handshake in the cycle it is raised.
    assign push = grp_vld_in_frm_FE & ~full_out_to_FE & ~mis_pred_in_frm_ROB;
    assign pop  = grp_vld_out_to_ID & ~stll_ftch_in_frm_ID & ~mis_pred_in_frm_ROB;

    always_comb begin
        wr_grp          = '0;
        wr_grp.inst     = inst_in_frm_FE;
        wr_grp.pc       = pc_in_frm_FE;
        wr_grp.recv_pc  = recv_pc_in_frm_FE;
        wr_grp.pred     = pred_result_in_frm_FE;
        wr_grp.slot_vld = slot_vld_in_frm_FE;
    end

    fetch_grp_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_ptr (wr_ptr),
        .wr_dat (wr_grp),
        .rd_ptr (rd_ptr),
        .rd_dat (head_grp)
    );

    always_ff @(posedge clk) begin
        if (rst || mis_pred_in_frm_ROB) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Decode infers slot validity from the opcode, so dead slots must read as NOP.
    always_comb begin
        inst_out_to_ID        = {SLOTS{NOP_INST}};
        pc_out_to_ID          = '0;
        recv_pc_out_to_ID     = '0;
        pred_result_out_to_ID = '0;
        if (!empty) begin
            pc_out_to_ID      = head_grp.pc;
            recv_pc_out_to_ID = head_grp.recv_pc;
            for (int b = 0; b < SLOTS; b++) begin
                if (head_grp.slot_vld[b]) begin
                    inst_out_to_ID[b*SLOT_W +: SLOT_W] = head_grp.inst[b*SLOT_W +: SLOT_W];
                    pred_result_out_to_ID[b]           = head_grp.pred[b];
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    assert property (@(posedge clk) disable iff (rst) !(push && full_out_to_FE));
    assert property (@(posedge clk) disable iff (rst) cnt <= DEPTH_CNT);

endmodule

// File: tb/tb_fetch_id_queue.sv
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_fetch_id_queue;

    localparam int          DEPTH = 4;
    localparam logic [15:0] NOP   = 16'h0000;
    localparam logic [63:0] N     = {4{NOP}};
    localparam logic [63:0] GA    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] GB    = 64'h5555_6666_7777_8888;
    localparam logic [63:0] GC    = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [63:0] GD    = 64'hDDDD_EEEE_FFFF_0123;
    localparam logic [63:0] GE    = 64'h4567_89AB_CDEF_1357;

    logic        clk = 1'b0;
    logic        rst;
    logic        grp_vld_in_frm_FE;
    logic [63:0] inst_in_frm_FE;
    logic [63:0] pc_in_frm_FE;
    logic [63:0] recv_pc_in_frm_FE;
    logic [3:0]  pred_result_in_frm_FE;
    logic [3:0]  slot_vld_in_frm_FE;
    logic        stll_ftch_in_frm_ID;
    logic        mis_pred_in_frm_ROB;
    logic        full_out_to_FE;
    logic        grp_vld_out_to_ID;
    logic [63:0] inst_out_to_ID;
    logic [63:0] pc_out_to_ID;
    logic [63:0] recv_pc_out_to_ID;
    logic [3:0]  pred_result_out_to_ID;
    logic [2:0]  cnt_out;

    always #5 clk = ~clk;

    fetch_id_queue #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP),
        .PTR_W    (2)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .grp_vld_in_frm_FE     (grp_vld_in_frm_FE),
        .inst_in_frm_FE        (inst_in_frm_FE),
        .pc_in_frm_FE          (pc_in_frm_FE),
        .recv_pc_in_frm_FE     (recv_pc_in_frm_FE),
        .pred_result_in_frm_FE (pred_result_in_frm_FE),
        .slot_vld_in_frm_FE    (slot_vld_in_frm_FE),
        .stll_ftch_in_frm_ID   (stll_ftch_in_frm_ID),
        .mis_pred_in_frm_ROB   (mis_pred_in_frm_ROB),
        .full_out_to_FE        (full_out_to_FE),
        .grp_vld_out_to_ID     (grp_vld_out_to_ID),
        .inst_out_to_ID        (inst_out_to_ID),
        .pc_out_to_ID          (pc_out_to_ID),
        .recv_pc_out_to_ID     (recv_pc_out_to_ID),
        .pred_result_out_to_ID (pred_result_out_to_ID),
        .cnt_out               (cnt_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] inst;
        logic [63:0] pc;
        logic [63:0] rpc;
        logic [3:0]  pred;
        logic [3:0]  sv;
    } grp_t;

    typedef struct {
        logic        rst;
        logic        gv;
        logic [63:0] inst;
        logic [3:0]  sv;
        logic [3:0]  pred;
        logic        stall;
        logic        mis;
        int          e_cnt;
        logic        e_vld;
        logic        e_full;
        logic [63:0] e_inst;
        logic [3:0]  e_pred;
    } vec_t;

    grp_t q[$];
    vec_t vecs[$];

    function automatic logic [63:0] pcf(input logic [63:0] i);
        return ~i;
    endfunction

    function automatic logic [63:0] rpcf(input logic [63:0] i);
        return {i[31:0], i[63:32]} ^ 64'h0F0F_0F0F_0F0F_0F0F;
    endfunction

    function automatic vec_t mk(input logic r, input logic gv, input logic [63:0] inst,
                                input logic [3:0] sv, input logic [3:0] pred,
                                input logic stall, input logic mis, input int e_cnt,
                                input logic e_vld, input logic e_full,
                                input logic [63:0] e_inst, input logic [3:0] e_pred);
        vec_t v;
        v.rst = r; v.gv = gv; v.inst = inst; v.sv = sv; v.pred = pred;
        v.stall = stall; v.mis = mis; v.e_cnt = e_cnt; v.e_vld = e_vld;
        v.e_full = e_full; v.e_inst = e_inst; v.e_pred = e_pred;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic gv, input logic [63:0] inst,
                         input logic [3:0] sv, input logic [3:0] pred,
                         input logic stall, input logic mis);
        rst                   = r;
        grp_vld_in_frm_FE     = gv;
        inst_in_frm_FE        = inst;
        pc_in_frm_FE          = pcf(inst);
        recv_pc_in_frm_FE     = rpcf(inst);
        slot_vld_in_frm_FE    = sv;
        pred_result_in_frm_FE = pred;
        stll_ftch_in_frm_ID   = stall;
        mis_pred_in_frm_ROB   = mis;
    endtask

    // Reference behaviour: a bounded FIFO of groups, emptied by reset or mispredict.
    task automatic model_step();
        grp_t g;
        grp_t dropped;
        bit   do_push;
        bit   do_pop;
        if (rst || mis_pred_in_frm_ROB) begin
            q.delete();
        end else begin
            do_push = grp_vld_in_frm_FE && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && !stll_ftch_in_frm_ID;
            if (do_pop) dropped = q.pop_front();
            if (do_push) begin
                g.inst = inst_in_frm_FE;
                g.pc   = pc_in_frm_FE;
                g.rpc  = recv_pc_in_frm_FE;
                g.pred = pred_result_in_frm_FE;
                g.sv   = slot_vld_in_frm_FE;
                q.push_back(g);
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] e_inst;
        logic [63:0] e_pc;
        logic [63:0] e_rpc;
        logic [3:0]  e_pred;
        e_inst = N;
        e_pc   = '0;
        e_rpc  = '0;
        e_pred = '0;
        if (q.size() > 0) begin
            e_pc  = q[0].pc;
            e_rpc = q[0].rpc;
            for (int s = 0; s < 4; s++) begin
                if (q[0].sv[3-s]) begin
                    e_inst[63-16*s -: 16] = q[0].inst[63-16*s -: 16];
                    e_pred[3-s]           = q[0].pred[3-s];
                end
            end
        end
        chk({tag, " m_cnt"},  64'(cnt_out),               64'(q.size()));
        chk({tag, " m_vld"},  64'(grp_vld_out_to_ID),     64'(q.size() > 0));
        chk({tag, " m_full"}, 64'(full_out_to_FE),        64'(q.size() == DEPTH));
        chk({tag, " m_inst"}, inst_out_to_ID,             e_inst);
        chk({tag, " m_pc"},   pc_out_to_ID,               e_pc);
        chk({tag, " m_rpc"},  recv_pc_out_to_ID,          e_rpc);
        chk({tag, " m_pred"}, 64'(pred_result_out_to_ID), 64'(e_pred));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] wrap_grps [6];
        logic [63:0] fill_grps [4];
        vec_t        v;
        string       tag;

        wrap_grps[0] = GA; wrap_grps[1] = GB; wrap_grps[2] = GC;
        wrap_grps[3] = GD; wrap_grps[4] = GE; wrap_grps[5] = GA;
        fill_grps[0] = GC; fill_grps[1] = GD; fill_grps[2] = GE; fill_grps[3] = GA;

        vecs.push_back(mk(1, 0, 64'h0, 4'hF, 4'hF, 0, 0, 0, 0, 0, N, 4'h0));
        vecs.push_back(mk(0, 1, GA,    4'hF, 4'hF, 0, 0, 1, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GB,    4'hF, 4'hF, 0, 0, 1, 1, 0, GB, 4'hF));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 0, 0, 0, N, 4'h0));
        vecs.push_back(mk(0, 1, GA,    4'hF, 4'hF, 1, 0, 1, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GB,    4'hF, 4'hF, 1, 0, 2, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GC,    4'hF, 4'hF, 1, 0, 3, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GD,    4'hF, 4'hF, 1, 0, 4, 1, 1, GA, 4'hF));
        vecs.push_back(mk(0, 1, GE,    4'hF, 4'hF, 1, 0, 4, 1, 1, GA, 4'hF));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 3, 1, 0, GB, 4'hF));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 2, 1, 0, GC, 4'hF));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 1, 1, 0, GD, 4'hF));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 0, 0, 0, N, 4'h0));
        vecs.push_back(mk(0, 1, GA,    4'hF, 4'hF, 1, 0, 1, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GB,    4'hF, 4'hF, 1, 0, 2, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GC,    4'hF, 4'hF, 1, 0, 3, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GD,    4'hF, 4'hF, 1, 0, 4, 1, 1, GA, 4'hF));
        // full: pop happens, push is refused
        vecs.push_back(mk(0, 1, GE,    4'hF, 4'hF, 0, 0, 3, 1, 0, GB, 4'hF));
        vecs.push_back(mk(0, 1, GE,    4'hF, 4'hF, 0, 0, 3, 1, 0, GC, 4'hF));
        vecs.push_back(mk(0, 1, GA,    4'hF, 4'hF, 1, 1, 0, 0, 0, N, 4'h0));
        vecs.push_back(mk(0, 1, GA,    4'hC, 4'hF, 1, 0, 1, 1, 0, 64'h1111_2222_0000_0000, 4'hC));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 0, 0, 0, N, 4'h0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 1, wrap_grps[i], 4'hF, 4'hF, 0, 0, 1, 1, 0, wrap_grps[i], 4'hF));
        vecs.push_back(mk(0, 0, 64'h0, 4'hF, 4'hF, 0, 0, 0, 0, 0, N, 4'h0));
        vecs.push_back(mk(0, 1, GA,    4'hF, 4'hF, 1, 0, 1, 1, 0, GA, 4'hF));
        vecs.push_back(mk(0, 1, GB,    4'hF, 4'hF, 1, 0, 2, 1, 0, GA, 4'hF));
        vecs.push_back(mk(1, 1, GC,    4'hF, 4'hF, 1, 0, 0, 0, 0, N, 4'h0));
        vecs.push_back(mk(1, 1, GD,    4'hF, 4'hF, 0, 1, 0, 0, 0, N, 4'h0));

        drive(1, 0, 64'h0, 4'h0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst, v.gv, v.inst, v.sv, v.pred, v.stall, v.mis);
            cycle();
            tag = $sformatf("vec%0d", i);
            chk({tag, " cnt"},  64'(cnt_out),               64'(v.e_cnt));
            chk({tag, " vld"},  64'(grp_vld_out_to_ID),     64'(v.e_vld));
            chk({tag, " full"}, 64'(full_out_to_FE),        64'(v.e_full));
            chk({tag, " inst"}, inst_out_to_ID,             v.e_inst);
            chk({tag, " pred"}, 64'(pred_result_out_to_ID), 64'(v.e_pred));
            check_model(tag);
        end

        // Held stall on a full queue: head must not move while pushes keep being offered.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, fill_grps[i], 4'hF, 4'h5, 1, 0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, GB, 4'hF, 4'hA, 1, 0);
            cycle();
            tag = $sformatf("hold%0d", i);
            chk({tag, " cnt"},  64'(cnt_out),        64'd4);
            chk({tag, " inst"}, inst_out_to_ID,      GC);
            chk({tag, " pc"},   pc_out_to_ID,        pcf(GC));
            check_model(tag);
        end
        drive(0, 1, GB, 4'hF, 4'hA, 0, 1);
        cycle();
        chk("flush_full cnt", 64'(cnt_out),           64'd0);
        chk("flush_full vld", 64'(grp_vld_out_to_ID), 64'd0);
        check_model("flush_full");

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  {$urandom, $urandom},
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 49) == 0);
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
